smi_master: RTL and testbench

SMI_MASTER -- requirements
Module: smi_master

---
 rtl/smi_master_if.sv | 22 ++
 rtl/smi_master.sv | 195 +++++++++++++++++++
 tb/tb_smi_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smi_master_if.sv
// Host-side request/response bundle of the SMI master.
// master = host view, slave = smi_master view.
interface smi_master_if;
  logic       REQ;
  logic       WR;
  logic [9:0] ADDR;
  logic [7:0] WDATA;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RDATA;
  logic       ERR;

  modport master (
    output REQ, WR, ADDR, WDATA,
    input  BUSY, DONE, RDATA, ERR
  );

  modport slave (
    input  REQ, WR, ADDR, WDATA,
    output BUSY, DONE, RDATA, ERR
  );
endinterface

// File: rtl/smi_master.sv
// SMI master: divided serial clock, LSB-first frames, strobed addr bus.
// Macro SMI_MASTER_PARITY_EN adds an odd-parity 9th frame bit.
module smi_master #(
  parameter int unsigned CLK_DIV      = 2,
  parameter logic [9:0]  SMI_ADDR_DIS = 10'b0
) (
  input  logic        CLKI,
  input  logic        RSTN,
  smi_master_if.slave host,
  output logic        SMICLK,
  output logic        SMIRSTN,
  output logic [9:0]  SMIADDR,
  output logic        SMIRD,
  output logic        SMIWR,
  output logic        SMIWDATA,
  input  logic        SMIRDATA
);
`ifdef SMI_MASTER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST   = 4'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_SHIFT, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [7:0]    cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wr_q, wr_d;
  logic [9:0]    alat_q, alat_d;
  logic [9:0]    saddr_q, saddr_d;
  logic [NB-1:0] tx_q, tx_d;
  logic [NB-1:0] rx_q, rx_d;
  logic [3:0]    bit_q, bit_d;
  logic          srd_q, srd_d;
  logic          swr_q, swr_d;
  logic          sdo_q, sdo_d;
  logic          done_q, done_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tick, rise, fall;
  logic [NB-1:0] frame;
  logic          rx_err;

`ifdef SMI_MASTER_PARITY_EN
  assign frame  = {~^host.WDATA, host.WDATA};
  assign rx_err = rx_q[8] != ~^rx_q[7:0];
`else
  assign frame  = host.WDATA;
  assign rx_err = 1'b0;
`endif

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) sync_q <= '0;
    else       sync_q <= {sync_q[0], 1'b1};
  end

  assign SMIRSTN = sync_q[1];
  assign tick    = SMIRSTN && (cnt_q == DIV_M1);
  assign rise    = tick && !sclk_q;
  assign fall    = tick && sclk_q;

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      wr_q    <= 1'b0;
      alat_q  <= '0;
      saddr_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      wr_q    <= wr_d;
      alat_q  <= alat_d;
      saddr_q <= saddr_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      srd_q   <= srd_d;
      swr_q   <= swr_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    wr_d    = wr_q;
    alat_d  = alat_q;
    saddr_d = saddr_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    srd_d   = srd_q;
    swr_d   = swr_q;
    sdo_d   = sdo_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (!SMIRSTN) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (host.REQ) begin
          wr_d    = host.WR;
          alat_d  = host.ADDR;
          tx_d    = frame;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fall) begin
          saddr_d = alat_q & ~SMI_ADDR_DIS;
          swr_d   = wr_q;
          srd_d   = !wr_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (fall) begin
          bit_d   = '0;
          sdo_d   = wr_q & tx_q[0];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Read bits land in the MSB and walk down to LSB order.
        if (rise && !wr_q)
          rx_d = {SMIRDATA, rx_q[NB-1:1]};
        if (fall) begin
          if (bit_q == LAST) begin
            swr_d   = 1'b0;
            srd_d   = 1'b0;
            sdo_d   = 1'b0;
            state_d = S_HOLD;
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = {1'b0, tx_q[NB-1:1]};
            sdo_d = wr_q & tx_q[1];
          end
        end
      end
      S_HOLD: begin
        if (fall) begin
          saddr_d = '0;
          done_d  = 1'b1;
          err_d   = !wr_q && rx_err;
          if (!wr_q)
            rdata_d = rx_q[7:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign host.BUSY  = (state_q != S_IDLE);
  assign host.DONE  = done_q;
  assign host.RDATA = rdata_q;
  assign host.ERR   = err_q;
  assign SMICLK     = sclk_q;
  assign SMIADDR    = saddr_q;
  assign SMIRD      = srd_q;
  assign SMIWR      = swr_q;
  assign SMIWDATA   = sdo_q;
endmodule

// File: tb/tb_smi_master.sv
// Testbench for smi_master: vector table, hand sequences, random
// transactions checked against a frame-level model and a bus monitor.
module tb_smi_master;
`ifdef SMI_MASTER_PARITY_EN
  localparam int NB  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 8;
  localparam bit PAR = 1'b0;
`endif
  localparam int         CLK_DIV = 2;
  localparam logic [9:0] DIS     = 10'h300;

  logic       CLKI = 1'b0;
  logic       RSTN;
  logic       tgt_bit = 1'b0;
  logic       SMICLK, SMIRSTN, SMIRD, SMIWR, SMIWDATA;
  logic [9:0] SMIADDR;
  logic       d_clk, d_rstn, d_rd, d_wr, d_wd;
  logic [9:0] d_addr;

  smi_master_if hif ();
  smi_master_if hif2 ();

  assign hif2.REQ   = hif.REQ;
  assign hif2.WR    = hif.WR;
  assign hif2.ADDR  = hif.ADDR;
  assign hif2.WDATA = hif.WDATA;

  smi_master #(.CLK_DIV(CLK_DIV)) u_dut (
    .CLKI(CLKI), .RSTN(RSTN), .host(hif),
    .SMICLK(SMICLK), .SMIRSTN(SMIRSTN),
    .SMIADDR(SMIADDR), .SMIRD(SMIRD), .SMIWR(SMIWR),
    .SMIWDATA(SMIWDATA), .SMIRDATA(tgt_bit)
  );

  smi_master #(.CLK_DIV(CLK_DIV), .SMI_ADDR_DIS(DIS)) u_dis (
    .CLKI(CLKI), .RSTN(RSTN), .host(hif2),
    .SMICLK(d_clk), .SMIRSTN(d_rstn),
    .SMIADDR(d_addr), .SMIRD(d_rd), .SMIWR(d_wr),
    .SMIWDATA(d_wd), .SMIRDATA(tgt_bit)
  );

  always #5 CLKI = ~CLKI;

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, both_cnt = 0, wd_bad = 0;
  int wd_glitch = 0, idle_bad = 0, addr_bad = 0;
  int m_len = 0, cyc = 0, tgt_idx = 0;
  bit prev_clk, prev_rd, prev_wr, prev_wd, prev_stb;
  bit in_txn, m_rd, m_wr, fall_s, stb_s;
  logic [9:0] m_addr, m_dis;
  logic [8:0] tgt_val = '0;
  bit wbits[$];
  logic [7:0] mdl_rdata = '0;

  // Bus monitor plus SMI target: drives read bits after each SMICLK fall.
  always @(posedge CLKI) begin
    #1;
    if (!RSTN) begin
      prev_clk = 0; prev_rd = 0; prev_wr = 0;
      prev_wd = 0; prev_stb = 0; in_txn = 0;
      tgt_bit = 1'b0;
    end else begin
      fall_s = prev_clk && !SMICLK;
      stb_s  = SMIRD || SMIWR;
      if (SMIRD && SMIWR) both_cnt++;
      if (!SMIWR && SMIWDATA) wd_bad++;
      if (!hif.BUSY && SMIADDR != 10'd0) idle_bad++;
      if (SMIWDATA != prev_wd && !fall_s) wd_glitch++;
      if (stb_s && !prev_stb) begin
        wbits.delete();
        cyc = 0; tgt_idx = 0; in_txn = 1;
        m_addr = SMIADDR; m_dis = d_addr;
        m_rd = SMIRD; m_wr = SMIWR;
      end else if (in_txn) begin
        cyc++;
      end
      if (stb_s && SMIADDR != m_addr) addr_bad++;
      if (fall_s && SMIWR && prev_wr) wbits.push_back(SMIWDATA);
      if (fall_s && SMIRD && prev_rd) begin
        tgt_bit = (tgt_idx < 9) ? tgt_val[tgt_idx] : 1'b0;
        tgt_idx++;
      end
      if (hif.DONE) begin
        done_cnt++; m_len = cyc; in_txn = 0;
      end
      prev_clk = SMICLK; prev_rd = SMIRD; prev_wr = SMIWR;
      prev_wd = SMIWDATA; prev_stb = stb_s;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKI);
    #2;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (hif.DONE) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input string tg);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!hif.BUSY) ok = 1;
      else tick();
    end
    chk({tg, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_reset(input string tg);
    chk({tg, "_busy"},  32'(hif.BUSY),  0);
    chk({tg, "_done"},  32'(hif.DONE),  0);
    chk({tg, "_rdata"}, 32'(hif.RDATA), 0);
    chk({tg, "_err"},   32'(hif.ERR),   0);
    chk({tg, "_clk"},   32'(SMICLK),    0);
    chk({tg, "_addr"},  32'(SMIADDR),   0);
    chk({tg, "_rd"},    32'(SMIRD),     0);
    chk({tg, "_wr"},    32'(SMIWR),     0);
    chk({tg, "_wd"},    32'(SMIWDATA),  0);
    chk({tg, "_srst"},  32'(SMIRSTN),   0);
  endtask

  function automatic logic [8:0] exp_frame(input logic [7:0] wd);
    bit p = ($countones(wd) % 2) == 0;
    return PAR ? {p, wd} : {1'b0, wd};
  endfunction

  task automatic do_txn(input bit wr, input logic [9:0] addr,
                        input logic [7:0] wd, input logic [8:0] tv,
                        input logic [9:0] ea, input logic [9:0] ed,
                        input logic [7:0] er, input bit ee,
                        input string tg);
    bit ok;
    int dc;
    logic [8:0] got;
    tgt_val = tv;
    wait_idle(tg);
    dc = done_cnt;
    hif.REQ = 1'b1; hif.WR = wr;
    hif.ADDR = addr; hif.WDATA = wd;
    tick();
    hif.REQ = 1'b0;
    chk({tg, "_busy"}, 32'(hif.BUSY), 1);
    wait_done(ok);
    chk({tg, "_done"}, 32'(ok), 1);
    chk({tg, "_rdata"}, 32'(hif.RDATA), 32'(er));
    chk({tg, "_err"}, 32'(hif.ERR), 32'(ee));
    chk({tg, "_bsy0"}, 32'(hif.BUSY), 0);
    chk({tg, "_a0"}, 32'(SMIADDR), 0);
    chk({tg, "_len"}, m_len, (NB + 2) * 2 * CLK_DIV);
    chk({tg, "_swr"}, 32'(m_wr), 32'(wr));
    chk({tg, "_srd"}, 32'(m_rd), 32'(!wr));
    chk({tg, "_addr"}, 32'(m_addr), 32'(ea));
    chk({tg, "_dis"}, 32'(m_dis), 32'(ed));
    got = '0;
    foreach (wbits[i]) if (i < 9) got[i] = wbits[i];
    chk({tg, "_nbits"}, wbits.size(), wr ? NB : 0);
    chk({tg, "_bits"}, 32'(got), wr ? 32'(exp_frame(wd)) : 0);
    tick();
    chk({tg, "_pulse"}, 32'(hif.DONE), 0);
    chk({tg, "_ndone"}, done_cnt - dc, 1);
  endtask

  typedef struct {
    bit         wr;
    logic [9:0] addr;
    logic [7:0] wd;
    logic [8:0] tv;
    logic [9:0] ea;
    logic [9:0] ed;
    logic [7:0] er;
    bit         ee;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit ok;
    int dc;
    logic [9:0] a;
    logic [7:0] d;
    logic [8:0] t;
    bit w, e;

    vt[0] = '{1'b1, 10'h3A5, 8'hC3, 9'h000,
              10'h3A5, 10'h0A5, 8'h00, 1'b0};
    vt[1] = '{1'b0, 10'h010, 8'h00, 9'h15A,
              10'h010, 10'h010, 8'h5A, 1'b0};
    vt[2] = '{1'b1, 10'h3FF, 8'h5A, 9'h000,
              10'h3FF, 10'h0FF, 8'h5A, 1'b0};
    vt[3] = '{1'b0, 10'h3FF, 8'h00, 9'h101,
              10'h3FF, 10'h0FF, 8'h01, PAR};
    vt[4] = '{1'b0, 10'h000, 8'h00, 9'h001,
              10'h000, 10'h000, 8'h01, 1'b0};
    vt[5] = '{1'b1, 10'h000, 8'h00, 9'h000,
              10'h000, 10'h000, 8'h01, 1'b0};

    hif.REQ = 1'b0; hif.WR = 1'b0;
    hif.ADDR = '0; hif.WDATA = '0;
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    tick();
    chk_reset("rst");
    tick();
    RSTN = 1'b1;
    tick();
    chk("sync1", 32'(SMIRSTN), 0);
    tick();
    chk("sync2", 32'(SMIRSTN), 1);
    chk("sync2_clk", 32'(SMICLK), 0);

    foreach (vt[i]) begin
      do_txn(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].tv,
             vt[i].ea, vt[i].ed, vt[i].er, vt[i].ee,
             $sformatf("vec%0d", i));
    end
    mdl_rdata = 8'h01;

    // Back-to-back writes with REQ held, plus an ignored mid-busy pulse.
    wait_idle("b2b");
    dc = done_cnt;
    hif.REQ = 1'b1; hif.WR = 1'b1;
    hif.ADDR = 10'h155; hif.WDATA = 8'h81;
    wait_done(ok);
    chk("b2b_done1", 32'(ok), 1);
    chk("b2b_addr1", 32'(m_addr), 32'h155);
    hif.ADDR = 10'h2AA; hif.WDATA = 8'h7E;
    tick();
    chk("b2b_busy2", 32'(hif.BUSY), 1);
    hif.REQ = 1'b0;
    repeat (10) tick();
    hif.REQ = 1'b1; hif.ADDR = 10'h3C3;
    tick();
    hif.REQ = 1'b0;
    wait_done(ok);
    chk("b2b_done2", 32'(ok), 1);
    chk("b2b_addr2", 32'(m_addr), 32'h2AA);
    chk("b2b_bits2", wbits.size(), NB);
    repeat (30) tick();
    chk("b2b_nothird", 32'(hif.BUSY), 0);
    chk("b2b_ndone", done_cnt - dc, 2);

    // Reset in the middle of a write, while bit 4 is on the wire.
    wait_idle("mid");
    dc = done_cnt;
    hif.REQ = 1'b1; hif.WR = 1'b1;
    hif.ADDR = 10'h0F0; hif.WDATA = 8'hFF;
    tick();
    hif.REQ = 1'b0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (wbits.size() >= 5) ok = 1;
    end
    chk("mid_bit4", 32'(ok), 1);
    chk("mid_wd1", 32'(SMIWDATA), 1);
    #1 RSTN = 1'b0;
    #1 chk_reset("mid");
    repeat (3) tick();
    RSTN = 1'b1;
    tick();
    chk("mid_sync1", 32'(SMIRSTN), 0);
    tick();
    chk("mid_sync2", 32'(SMIRSTN), 1);
    chk("mid_nodone", done_cnt - dc, 0);
    chk("mid_rdata", 32'(hif.RDATA), 0);
    mdl_rdata = '0;

    for (int k = 0; k < 12; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 10'($urandom);
      d = 8'($urandom);
      t = 9'($urandom);
      e = PAR && !w && (($countones(t) % 2) == 0);
      if (!w) mdl_rdata = t[7:0];
      do_txn(w, a, d, t, a, a & ~DIS, mdl_rdata, e,
             $sformatf("rnd%0d", k));
    end

    chk("both_strobes", both_cnt, 0);
    chk("wd_outside_wr", wd_bad, 0);
    chk("wd_off_fall", wd_glitch, 0);
    chk("addr_idle", idle_bad, 0);
    chk("addr_unstable", addr_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
